// File: rtl/dmem_wait_ctrl.sv
// Word-addressed data memory with valid/ready request channel, per-access programmable
// wait states, non-power-of-two depth and out-of-range error reporting.
module dmem_wait_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 65536,
   parameter int WAIT_W     = 4,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rd,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [WAIT_W-1:0]     wait_cfg,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic                  rd_q, rd_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [WAIT_W-1:0]     wcnt_q, wcnt_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic [WAIT_W-1:0]     wait_clamped;
   logic                  accept;
   logic                  wr_en;
   logic [IDX_W-1:0]      idx;

   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   assign accept = req_valid && ready_q;
   assign wait_clamped = (int'(wait_cfg) > MAX_WAIT) ? WAIT_W'(MAX_WAIT) : wait_cfg;

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         WAIT: begin
            wcnt_d = wcnt_q - WAIT_W'(1);
            if (wcnt_q <= WAIT_W'(1)) state_d = RESP;
         end
         default: begin
            // IDLE and RESP both accept; RESP falls back to IDLE when nothing arrives
            state_d = IDLE;
            if (accept) begin
               rd_d    = req_rd;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wcnt_d  = wait_clamped;
               state_d = (wait_clamped == '0) ? RESP : WAIT;
            end
         end
      endcase
      valid_d = (state_d == RESP);
      err_d   = (state_d == RESP) && ({1'b0, addr_d} >= (ADDR_WIDTH + 1)'(DEPTH));
      ready_d = (state_d != WAIT);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wcnt_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wcnt_q  <= wcnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Gated on the reset-cleared valid flag so an access dropped by reset never commits
   assign idx   = addr_q[IDX_W-1:0];
   assign wr_en = valid_q && !rd_q && !err_q;

   always_ff @(posedge clock) begin
      if (wr_en) mem[idx] <= wdata_q;
   end

   assign req_ready  = ready_q;
   assign resp_valid = valid_q;
   assign resp_err   = err_q;
   assign busy       = busy_q;
   assign resp_rdata = (valid_q && rd_q && !err_q) ? mem[idx] : '0;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Self-checking bench for dmem_wait_ctrl: vector table driven through a latency-aware
// scoreboard, plus hand-written wait-state, reset and clamp sequences.
module tb_dmem_wait_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_valid7 = 1'b0;
   logic        req_rd = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [3:0]  wait_cfg = '0;
   logic        req_ready, resp_valid, resp_err, busy;
   logic [15:0] resp_rdata;
   logic        req_ready7, resp_valid7, resp_err7, busy7;
   logic [15:0] resp_rdata7;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   dmem_wait_ctrl #(.DEPTH(1000)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata), .wait_cfg(wait_cfg),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
   );

   dmem_wait_ctrl #(.DEPTH(64), .MAX_WAIT(7)) dut7 (
      .clock(clock), .reset(reset), .req_valid(req_valid7), .req_ready(req_ready7),
      .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata), .wait_cfg(wait_cfg),
      .resp_valid(resp_valid7), .resp_rdata(resp_rdata7), .resp_err(resp_err7), .busy(busy7)
   );

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [3:0]  wcfg;
      logic [15:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      logic        chk_rdata;
      int          due;
      int          id;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   next_id = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every response must match the oldest expectation, in its due cycle
   always @(negedge clock) begin
      if (reset) begin
         if (resp_valid) begin
            tests++;
            if (sbq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
               e = sbq.pop_front();
               if (resp_err !== e.err || (e.chk_rdata && resp_rdata !== e.rdata) || cyc != e.due) begin
                  fails++;
                  $display("FAIL sb#%0d: got rdata=%0h err=%0b cycle=%0d expected rdata=%0h err=%0b cycle=%0d",
                           e.id, resp_rdata, resp_err, cyc, e.rdata, e.err, e.due);
               end
            end
         end else begin
            if (resp_err !== 1'b0 || resp_rdata !== 16'h0) begin
               tests++;
               fails++;
               $display("FAIL idle_outputs: got err=%0b rdata=%0h expected 0/0 (cycle %0d)", resp_err, resp_rdata, cyc);
            end
            if (sbq.size() > 0 && cyc >= sbq[0].due) begin
               e = sbq.pop_front();
               tests++;
               fails++;
               $display("FAIL sb#%0d_late: got no response at cycle %0d expected response at cycle %0d", e.id, cyc, e.due);
            end
         end
      end
   end

   task automatic do_req(input logic rd, input logic [15:0] a, input logic [15:0] wd,
                         input logic [3:0] wc, input logic [15:0] er, input logic ee);
      int g;
      exp_t x;
      @(negedge clock);
      req_valid = 1'b1; req_rd = rd; req_addr = a; req_wdata = wd; wait_cfg = wc;
      g = 0;
      while (!req_ready && g < 40) begin
         @(negedge clock);
         g++;
      end
      if (!req_ready) begin
         chk("accept_timeout", {31'b0, req_ready}, 32'd1);
      end else begin
         x.rdata = er; x.err = ee; x.chk_rdata = rd;
         x.due = cyc + 1 + int'(wc); x.id = next_id++;
         sbq.push_back(x);
      end
      @(posedge clock);
   endtask

   task automatic drain();
      int g;
      @(negedge clock);
      req_valid = 1'b0;
      g = 0;
      while (sbq.size() != 0 && g < 40) begin
         @(negedge clock);
         g++;
      end
      if (sbq.size() != 0) begin
         chk("drain_timeout", sbq.size(), 32'd0);
         sbq.delete();
      end
   endtask

   vec_t vecs[12];

   initial begin
      int c0;
      int g;
      vecs[0]  = '{1'b0, 16'h0010, 16'h1234, 4'd0,  16'h0000, 1'b0};
      vecs[1]  = '{1'b1, 16'h0010, 16'h0000, 4'd0,  16'h1234, 1'b0};
      vecs[2]  = '{1'b0, 16'h0005, 16'hBEEF, 4'd0,  16'h0000, 1'b0};
      vecs[3]  = '{1'b1, 16'h0005, 16'h0000, 4'd0,  16'hBEEF, 1'b0};
      vecs[4]  = '{1'b0, 16'd999,  16'h0777, 4'd1,  16'h0000, 1'b0};
      vecs[5]  = '{1'b0, 16'd1000, 16'hAAAA, 4'd0,  16'h0000, 1'b1};
      vecs[6]  = '{1'b1, 16'd1000, 16'h0000, 4'd2,  16'h0000, 1'b1};
      vecs[7]  = '{1'b1, 16'd999,  16'h0000, 4'd0,  16'h0777, 1'b0};
      vecs[8]  = '{1'b1, 16'h0010, 16'h0000, 4'd15, 16'h1234, 1'b0};
      vecs[9]  = '{1'b0, 16'hFFFF, 16'h1111, 4'd5,  16'h0000, 1'b1};
      vecs[10] = '{1'b1, 16'h0000, 16'h0000, 4'd0,  16'h0000, 1'b0};
      vecs[11] = '{1'b1, 16'h0005, 16'h0000, 4'd7,  16'hBEEF, 1'b0};

      repeat (2) @(negedge clock);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_busy",       {31'b0, busy},       32'd0);
      chk("rst_resp_err",   {31'b0, resp_err},   32'd0);
      chk("rst_resp_rdata", {16'b0, resp_rdata}, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_req_ready",  {31'b0, req_ready},  32'd1);

      // Table vectors, issued back-to-back
      for (int i = 0; i < 12; i++)
         do_req(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wcfg, vecs[i].exp_rdata, vecs[i].exp_err);
      drain();

      // Three wait states: stalled and busy for exactly three cycles
      do_req(1'b1, 16'h0010, 16'h0, 4'd3, 16'h1234, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         req_valid = 1'b0;
         chk("wait3_busy",  {31'b0, busy},      32'd1);
         chk("wait3_ready", {31'b0, req_ready}, 32'd0);
      end
      drain();

      // Held request during WAIT with a changing wait_cfg
      do_req(1'b1, 16'h0005, 16'h0, 4'd2, 16'hBEEF, 1'b0);
      @(negedge clock);
      req_valid = 1'b1; req_rd = 1'b1; req_addr = 16'h0010; wait_cfg = 4'd9;
      chk("hold_ready_w1", {31'b0, req_ready}, 32'd0);
      @(negedge clock);
      wait_cfg = 4'd6;
      chk("hold_ready_w2", {31'b0, req_ready}, 32'd0);
      @(negedge clock);
      wait_cfg = 4'd1;
      chk("hold_ready_resp", {31'b0, req_ready}, 32'd1);
      e.rdata = 16'h1234; e.err = 1'b0; e.chk_rdata = 1'b1; e.due = cyc + 2; e.id = next_id++;
      sbq.push_back(e);
      @(posedge clock);
      drain();

      // Reset two cycles into a 4-wait write: the write must never commit
      do_req(1'b0, 16'h0007, 16'h5555, 4'd4, 16'h0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      req_valid = 1'b0;
      sbq.delete();
      #1;
      chk("midrst_busy",       {31'b0, busy},       32'd0);
      chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("midrst_req_ready",  {31'b0, req_ready},  32'd1);
      @(negedge clock);
      reset = 1'b1;
      repeat (8) @(negedge clock);
      do_req(1'b1, 16'h0007, 16'h0, 4'd0, 16'h0000, 1'b0);
      drain();

      // Clamp on a MAX_WAIT=7 instance: wait_cfg=12 behaves as 7
      @(negedge clock);
      req_rd = 1'b1; req_addr = 16'h0; wait_cfg = 4'd12; req_valid7 = 1'b1;
      chk("clamp_ready", {31'b0, req_ready7}, 32'd1);
      c0 = cyc;
      @(negedge clock);
      req_valid7 = 1'b0;
      g = 0;
      while (!resp_valid7 && g < 30) begin
         @(negedge clock);
         g++;
      end
      chk("clamp_resp_seen",  {31'b0, resp_valid7}, 32'd1);
      chk("clamp_latency",    cyc,                  c0 + 1 + 7);
      chk("clamp_resp_err",   {31'b0, resp_err7},   32'd0);
      chk("clamp_resp_rdata", {16'b0, resp_rdata7}, 32'd0);
      @(negedge clock);
      chk("clamp_pulse_one",  {31'b0, resp_valid7}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/dmem_wait_ctrl.md
Name: dmem_wait_ctrl

Overview:
- Parametrised successor to the fixed LC3 data-memory model. Word-addressed data memory with a valid/ready request channel and a one-cycle response pulse.
- Adds a wait-state count that is programmable per access, a depth that need not be a power of two, and out-of-range error reporting.
- Sits between the LC3 MemAccess stage (or the dmem agent's BFM) and the memory array. One access is in flight at a time; a new request can be issued back-to-back in the response cycle.

Parameters:
- DATA_WIDTH, 16: data word width in bits.
- ADDR_WIDTH, 16: request address width in bits.
- DEPTH, 65536: number of implemented words; valid addresses are 0..DEPTH-1. Must be ≤ 2^ADDR_WIDTH.
- WAIT_W, 4: width of wait_cfg.
- MAX_WAIT, 15: wait_cfg values above this are clamped to MAX_WAIT.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_rd  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- wait_cfg  in  WAIT_W  wait states for this access; sampled on accept.
- resp_valid  out  1  one-cycle completion pulse (replaces complete_data).
- resp_rdata  out  DATA_WIDTH  read data; valid while resp_valid=1.
- resp_err  out  1  address out of range; valid while resp_valid=1.
- busy  out  1  an access is in flight (state ≠ IDLE).

Behaviour:
- States: IDLE, WAIT, RESP.
- Accept condition: req_valid && req_ready.
  - req_ready = 1 in IDLE and RESP; 0 in WAIT.
- On accept, latch rd, addr, wdata and wcnt = min(wait_cfg, MAX_WAIT).
  - If wcnt = 0, next state is RESP; otherwise next state is WAIT.
- WAIT: decrement wcnt each cycle. When wcnt reaches 1, next state is RESP.
- RESP: resp_valid = 1 for exactly one cycle.
  - Write: array[addr] ← wdata on the clock edge that ends RESP.
  - Read: resp_rdata = array[addr], read combinationally from the array in RESP.
  - Next state: WAIT or RESP if a new request is accepted in this cycle, else IDLE.
- Latency: request accepted at edge T, with N = clamped wait count → resp_valid is high in the cycle starting at edge T+1+N.
  - Throughput with back-to-back requests: 1 access per N+1 cycles.
- Out-of-range (addr ≥ DEPTH): no array write; resp_rdata = 0; resp_err = 1. Remaining timing is identical to a normal access.
- Read accepted in the RESP cycle of a write to the same address returns the new data, because the write commits before the read's RESP.
- Outside RESP: resp_valid = 0, resp_err = 0, resp_rdata = 0.
- Reset asserted (reset = 0):
  - state → IDLE, wcnt → 0; resp_valid, resp_err, busy → 0; resp_rdata → 0; req_ready → 1 once reset is released.
  - An in-flight access is dropped. A write not yet in its commit edge does not commit.
  - Array contents are not reset. Every word is initialised to 0 at time zero.
- req_valid in WAIT is ignored (req_ready = 0). The requester must hold the request until accepted.
- wait_cfg changes after accept have no effect on the access in flight.

Test Plan:
- Reset, then write 0x1234 to addr 0x0010 with wait_cfg = 0, then read 0x0010 with wait_cfg = 0 → write resp_valid at T+1; read resp_valid at T'+1 with resp_rdata = 0x1234, resp_err = 0.
- Read with wait_cfg = 3 → req_ready = 0 and busy = 1 for 3 cycles; resp_valid at T+4. wait_cfg = 15 → resp at T+16. With MAX_WAIT = 7 and wait_cfg = 12 → resp at T+8.
- Back-to-back: write 0xBEEF to addr 5, then a read of addr 5 issued in the write's RESP cycle (both wait_cfg = 0) → read resp_valid on the next cycle, resp_rdata = 0xBEEF, and no idle cycle between the two responses.
- DEPTH = 1000: write 0xAAAA to addr 1000, then read addr 1000 → both responses have resp_err = 1; the read returns 0x0000; a read of addr 999 returns its prior value, unchanged.
- Write 0x5555 to addr 7 with wait_cfg = 4; assert reset two cycles after accept → outputs go to reset values immediately, resp_valid never pulses; a later read of addr 7 returns 0x0000.
- Hold req_valid through a WAIT period with a changing wait_cfg → only the first request's latency is applied; the second request is accepted in RESP and uses the wait_cfg value present at its accept edge.
